// File: rtl/score_pkg.sv
// Shared constants, FSM encoding and BCD digit helpers for the score keeper.
package score_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Returns {cout, digit}; the 4-bit wrap of sum-10 is exact for sums 10..19.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       cin);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (sum > 5'd9) begin
      return {1'b1, sum[3:0] - 4'd10};
    end else begin
      return {1'b0, sum[3:0]};
    end
  endfunction

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single BCD digit adder with carry in/out.
module bcd_digit_adder
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] digit,
  output logic             cout
);

  assign {cout, digit} = bcd_digit_add(a, b, cin);

endmodule

// File: rtl/score_keeper.sv
// Running BCD score with digit-serial addition, atomic publish, tick divider
// and session high score.
module score_keeper
  import score_pkg::*;
#(
  parameter int MAX_DIGITS  = 6,
  parameter int ADD_DIGITS  = 4,
  parameter int TICK_DIV    = 25000000,
  parameter int TICK_POINTS = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        clear,
  input  logic                        add_valid,
  output logic                        add_ready,
  input  logic [BCD_W*ADD_DIGITS-1:0] add_bcd,
  output logic [BCD_W*MAX_DIGITS-1:0] score_bcd,
  output logic [BCD_W*MAX_DIGITS-1:0] hi_bcd,
  output logic                        saturated,
  output logic                        busy
);

  localparam int SCORE_W = BCD_W * MAX_DIGITS;
  localparam int IDX_W   = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(MAX_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]       TICK_DIGIT = bcd_clamp(4'(TICK_POINTS));

  state_t               state_r, state_nx_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 pend_r, wrap_s;
  logic [SCORE_W-1:0]   work_r, op_r, score_r, hi_r, op_load_s, commit_val_s;
  logic [IDX_W-1:0]     idx_r;
  logic                 carry_r, sat_r;
  logic                 load_tick_s, load_bonus_s, ready_s;
  logic [BCD_W-1:0]     sum_digit_s;
  logic                 sum_cout_s;

  assign wrap_s       = run && (cnt_r == CNT_LAST);
  assign commit_val_s = carry_r ? {MAX_DIGITS{BCD_MAX}} : work_r;

  // Tick divider; a wrap while a tick is still pending is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= {CNT_W{1'b0}};
      pend_r <= 1'b0;
    end else if (clear) begin
      cnt_r  <= {CNT_W{1'b0}};
      pend_r <= 1'b0;
    end else begin
      if (run) begin
        cnt_r <= wrap_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      end
      if (load_tick_s) begin
        pend_r <= 1'b0;
      end else if (wrap_s) begin
        pend_r <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state, handshake and load strobes; a pending tick beats a bonus.
  always_comb begin
    state_nx_s   = state_r;
    ready_s      = 1'b0;
    load_tick_s  = 1'b0;
    load_bonus_s = 1'b0;
    if (clear || !reset) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (pend_r) begin
            load_tick_s = 1'b1;
            state_nx_s  = ADD;
          end else begin
            ready_s = 1'b1;
            if (add_valid) begin
              load_bonus_s = 1'b1;
              state_nx_s   = ADD;
            end else begin
              state_nx_s = IDLE;
            end
          end
        end
        ADD: begin
          if (idx_r == LAST_IDX) begin
            state_nx_s = COMMIT;
          end else begin
            state_nx_s = ADD;
          end
        end
        COMMIT:  state_nx_s = IDLE;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // Operand selection with A-F digits clamped to 9.
  always_comb begin
    op_load_s = {SCORE_W{1'b0}};
    if (load_tick_s) begin
      op_load_s[BCD_W-1:0] = TICK_DIGIT;
    end else begin
      for (int i = 0; i < ADD_DIGITS; i++) begin
        op_load_s[i*BCD_W +: BCD_W] = bcd_clamp(add_bcd[i*BCD_W +: BCD_W]);
      end
    end
  end

  bcd_digit_adder u_adder (
    .a     (work_r[idx_r*BCD_W +: BCD_W]),
    .b     (op_r[idx_r*BCD_W +: BCD_W]),
    .cin   (carry_r),
    .digit (sum_digit_s),
    .cout  (sum_cout_s)
  );

  // Working copy is built serially; score and high score change only in COMMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work_r  <= {SCORE_W{1'b0}};
      op_r    <= {SCORE_W{1'b0}};
      score_r <= {SCORE_W{1'b0}};
      hi_r    <= {SCORE_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      carry_r <= 1'b0;
      sat_r   <= 1'b0;
    end else if (clear) begin
      score_r <= {SCORE_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      carry_r <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_tick_s || load_bonus_s) begin
            work_r  <= score_r;
            op_r    <= op_load_s;
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= 1'b0;
          end
        end
        ADD: begin
          work_r[idx_r*BCD_W +: BCD_W] <= sum_digit_s;
          carry_r <= sum_cout_s;
          idx_r   <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end
        COMMIT: begin
          score_r <= commit_val_s;
          if (carry_r) begin
            sat_r <= 1'b1;
          end
          if (commit_val_s > hi_r) begin
            hi_r <= commit_val_s;
          end
        end
        default: begin
          carry_r <= 1'b0;
        end
      endcase
    end
  end

  assign add_ready = ready_s;
  assign score_bcd = score_r;
  assign hi_bcd    = hi_r;
  assign saturated = sat_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_score_keeper.sv
// Directed scoreboard bench for score_keeper with TICK_DIV=4, MAX_DIGITS=6.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        reset, run, clear, add_valid, add_ready, saturated, busy;
  logic [15:0] add_bcd;
  logic [23:0] score_bcd, hi_bcd;

  typedef struct {
    logic [23:0] score;
    logic [23:0] hi;
    logic        sat;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_score = 0;
  int   exp_hi = 0;
  logic exp_sat = 1'b0;

  score_keeper #(.MAX_DIGITS(6), .ADD_DIGITS(4), .TICK_DIV(4), .TICK_POINTS(1)) dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear),
    .add_valid(add_valid), .add_ready(add_ready), .add_bcd(add_bcd),
    .score_bcd(score_bcd), .hi_bcd(hi_bcd), .saturated(saturated), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int bcd_val(input logic [15:0] a);
    int s, m, d;
    s = 0;
    m = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(a[i*4 +: 4]);
      if (d > 9) d = 9;
      s = s + d * m;
      m = m * 10;
    end
    return s;
  endfunction

  function automatic void model_add(input int amt);
    exp_t e;
    exp_score = exp_score + amt;
    if (exp_score > 999999) begin
      exp_score = 999999;
      exp_sat   = 1'b1;
    end
    if (exp_score > exp_hi) exp_hi = exp_score;
    e.score = to_bcd(exp_score);
    e.hi    = to_bcd(exp_hi);
    e.sat   = exp_sat;
    q.push_back(e);
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_front(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = q.pop_front();
      check({tag, "_score"}, score_bcd, e.score);
      check({tag, "_hi"}, hi_bcd, e.hi);
      check({tag, "_sat"}, {23'd0, saturated}, {23'd0, e.sat});
    end
  endtask

  // Called at the first negedge after the load edge.
  task automatic finish_op(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 24'(n), 24'd7);
    check_front(tag);
  endtask

  task automatic do_bonus(input logic [15:0] amt, input string tag);
    int n;
    n = 0;
    while (add_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_ready"}, {23'd0, add_ready}, 24'd1);
    add_valid = 1'b1;
    add_bcd   = amt;
    model_add(bcd_val(amt));
    @(negedge clk);
    add_valid = 1'b0;
    finish_op(tag);
  endtask

  initial begin
    int n;
    reset = 1'b0; run = 1'b0; clear = 1'b0; add_valid = 1'b0; add_bcd = 16'h0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run   = 1'b1;
    repeat (6) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("rst_score", score_bcd, 24'h000000);
    check("rst_hi", hi_bcd, 24'h000000);
    check("rst_sat", {23'd0, saturated}, 24'd0);
    check("rst_busy", {23'd0, busy}, 24'd0);
    check("rst_ready", {23'd0, add_ready}, 24'd0);
    @(negedge clk);
    reset = 1'b1;

    // First tick: wrap on the 4th counting edge, then a 7-cycle addition.
    repeat (3) @(negedge clk);
    check("tick_not_yet", {23'd0, add_ready}, 24'd1);
    @(negedge clk);
    check("tick_pending_ready", {23'd0, add_ready}, 24'd0);
    check("tick_pending_busy", {23'd0, busy}, 24'd0);
    run = 1'b0;
    model_add(1);
    @(negedge clk);
    finish_op("tick1");

    do_bonus(16'h0094, "b95");
    do_bonus(16'h0007, "b102");

    // Clear during the 3rd ADD cycle aborts the bonus.
    add_valid = 1'b1;
    add_bcd   = 16'h0050;
    @(negedge clk);
    add_valid = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_score = 0;
    check("clr_score", score_bcd, 24'h000000);
    check("clr_busy", {23'd0, busy}, 24'd0);
    check("clr_hi", hi_bcd, 24'h000102);

    // Pending tick blocks a simultaneous bonus until it commits.
    do_bonus(16'h0010, "b10");
    run = 1'b1;
    repeat (4) @(negedge clk);
    run       = 1'b0;
    add_valid = 1'b1;
    add_bcd   = 16'h0020;
    model_add(1);
    n = 0;
    while (add_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("tick_block_cycles", 24'(n), 24'd8);
    check_front("tick_first");
    model_add(20);
    @(negedge clk);
    add_valid = 1'b0;
    finish_op("bonus_after_tick");

    // Clear cycle drops add_ready; then a hex digit is clamped to 9.
    clear = 1'b1;
    #1;
    check("clr_ready", {23'd0, add_ready}, 24'd0);
    @(negedge clk);
    clear = 1'b0;
    exp_score = 0;
    check("clr2_score", score_bcd, 24'h000000);
    do_bonus(16'h000C, "clamp");

    // Drive to 999990, then saturate.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_score = 0;
    for (int i = 0; i < 100; i++) do_bonus(16'h9999, "fill");
    do_bonus(16'h0090, "b999990");
    do_bonus(16'h0015, "sat");
    run = 1'b1;
    repeat (4) @(negedge clk);
    run = 1'b0;
    model_add(1);
    @(negedge clk);
    finish_op("sat_tick");

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr3_sat", {23'd0, saturated}, 24'd0);
    check("clr3_score", score_bcd, 24'h000000);
    check("clr3_hi", hi_bcd, 24'h999999);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Upstream stage of the on-screen scoreboard: owns the player's running score as packed BCD digits, which the scoreboard renderer reads directly.
- Accumulates distance points from an internal tick divider and bonus points from a valid/ready handshake.
- Additions run digit-serially; the published score changes atomically, so the display never shows a half-updated value.
- Also keeps a session high score.

Parameters:
- MAX_DIGITS, 6, number of BCD digits in score and high score.
- ADD_DIGITS, 4, number of BCD digits in a bonus amount.
- TICK_DIV, 25000000, clk cycles between distance ticks while run=1.
- TICK_POINTS, 1, binary value 0-9 added to digit 0 on each distance tick.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- run  input  1  enables the tick divider; 0 freezes it and holds its count.
- clear  input  1  synchronous score restart; high score is kept.
- add_valid  input  1  bonus request valid.
- add_ready  output  1  bonus request accepted when valid&ready.
- add_bcd  input  4*ADD_DIGITS  bonus amount, BCD; digit 0 in [3:0].
- score_bcd  output  4*MAX_DIGITS  current score; digit 0 (least significant) in [3:0].
- hi_bcd  output  4*MAX_DIGITS  high score, same layout.
- saturated  output  1  sticky; set once the score has clamped at all 9s.
- busy  output  1  an addition is in progress.

Behaviour:
Reset (reset=0, asynchronous):
- score_bcd=0, hi_bcd=0, saturated=0, busy=0, add_ready=0.
- Divider count=0, pending_tick=0, FSM=IDLE.

Tick divider:
- While run=1 the divider counts 0..TICK_DIV-1.
- At wrap it sets pending_tick=1 for one pulse; pending_tick stays latched until the tick is consumed.
- A second wrap while pending_tick=1 is dropped, not queued.

FSM states: IDLE, ADD, COMMIT.
- IDLE, pending_tick=1: load operand = TICK_POINTS in digit 0, zeros above; clear pending_tick; go to ADD. The tick has priority over a bonus.
- IDLE, pending_tick=0: add_ready=1 (combinational, in IDLE only). On add_valid&add_ready, load operand = add_bcd zero-extended to MAX_DIGITS digits; go to ADD.
- ADD: takes exactly MAX_DIGITS cycles, one digit per cycle starting at digit 0.
  - sum = work[i] + op[i] + carry.
  - If sum > 9: digit = sum - 10 and carry = 1; otherwise digit = sum and carry = 0.
  - The working copy is separate from score_bcd.
- COMMIT (1 cycle):
  - Carry out of the top digit: score_bcd = all 9s and saturated = 1.
  - Otherwise score_bcd = working copy.
  - If the new score > hi_bcd (unsigned compare of the packed vectors, which is valid for BCD), hi_bcd = new score, in the same cycle.
  - Go to IDLE.
- busy=1 in ADD and COMMIT.
- Latency: accept/load edge to score_bcd update = MAX_DIGITS+1 cycles. Throughput is one addition per MAX_DIGITS+2 cycles.

Operand digits > 9 (A-F) are clamped to 9 at load.

Saturated state:
- While saturated=1 the score is already all 9s; further additions still run and leave it all 9s.

clear=1 (priority over everything except reset):
- score_bcd=0, saturated=0, pending_tick=0, divider count=0.
- An in-progress ADD or COMMIT is aborted; FSM goes to IDLE; hi_bcd is unchanged.
- add_ready=0 in the clear cycle.

Simultaneous events:
- Tick wrap in the same cycle as a bonus handshake in IDLE: pending_tick was 0, so the bonus is accepted. The new tick latches and is serviced after the bonus commits.

Decomposition:
- Package score_pkg holds:
  - BCD_W=4 and BCD_MAX=9 constants.
  - The state encoding (IDLE, ADD, COMMIT).
  - A function bcd_digit_add(a, b, cin) returning {cout, digit}.
- One sub-module is natural: bcd_digit_adder, the combinational single-digit add with carry, instantiated once and reused serially.
- Digit indexing uses a counter of width clog2(MAX_DIGITS).

Test Plan (bench uses TICK_DIV=4, MAX_DIGITS=6):
- Reset low mid-run, then release -> all outputs 0; with run=1 the first tick fires at the 4th count and score_bcd = 000001 after 7 further cycles (MAX_DIGITS+1).
- score 000095 plus bonus add_bcd=0007 -> after handshake, busy for 7 cycles, then score_bcd = 000102; hi_bcd = 000102.
- score 999990 plus bonus 0015 -> score_bcd = 999999, saturated = 1; a following tick leaves 999999.
- clear asserted during the 3rd ADD cycle of a bonus -> next cycle score_bcd = 0, busy = 0, hi_bcd keeps its prior value (e.g. 000102).
- pending tick and add_valid both present in IDLE -> add_ready = 0 until the tick commits; the bonus is then accepted and both additions are reflected (e.g. 000010 + 1 + 0020 = 000031).
- add_bcd digit 0 = 0xC -> treated as 9 (000000 + 000C -> 000009).
